// File: rtl/if_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC and issues halfword reads
// over a req/ack handshake. Returned halfwords go into a circular queue, and
// complete 16/32/48-bit instructions are presented to decode with valid/ready.
// A redirect flushes the queue and restarts fetch. A request that is still
// in flight during a redirect is waited out (DROP) and its data is discarded.
module if_sequencer #(
    parameter int          QDEPTH   = 4,
    parameter logic [24:0] RESET_PC = 25'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [24:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [24:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [63:0] inst_o,
    output logic [1:0]  inst_len_o,
    output logic [24:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic {RUN, DROP} state_t;

    state_t          state_reg, state_next;
    logic [24:0]     fpc_reg, fpc_next;
    logic [24:0]     head_pc_reg, head_pc_next;
    logic [PW-1:0]   head_ptr_reg, head_ptr_next;
    logic [PW-1:0]   tail_ptr_reg, tail_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            req_reg, req_next;
    logic [24:0]     addr_reg, addr_next;

    logic [15:0]     queue_mem [QDEPTH];

    logic [PW-1:0]   hw_ptr  [3];
    logic [15:0]     hw_data [3];
    logic [1:0]      len_raw;
    logic [1:0]      need;
    logic            push;
    logic            pop;
    logic [CW-1:0]   pop_n;
    logic [24:0]     redir_pc;

    // Circular pointer advance by n slots (n <= 3 < 2*QDEPTH)
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= (PW+1)'(QDEPTH))
            s = s - (PW+1)'(QDEPTH);
        return s[PW-1:0];
    endfunction

    // The three halfwords starting at the queue head, zeroed beyond the
    // instruction length or the valid queue contents
    for (genvar gi = 0; gi < 3; gi++) begin : g_hw
        assign hw_ptr[gi]  = ptr_add(head_ptr_reg, 2'(gi));
        assign hw_data[gi] = queue_mem[hw_ptr[gi]];
        assign inst_o[16*gi +: 16] = ((count_reg > CW'(gi)) && (len_raw >= 2'(gi)))
                                     ? hw_data[gi] : 16'h0000;
    end
    assign inst_o[63:48] = 16'h0000;

    // Length decode of the head halfword
    always_comb begin
        len_raw = 2'd0;
        if ((hw_data[0][10:5] == 6'b110001) && (hw_data[0][15:11] == 5'b00000))
            len_raw = 2'd2;
        else if (hw_data[0][10:9] == 2'b11)
            len_raw = 2'd1;
    end

    assign need         = len_raw + 2'd1;
    assign inst_len_o   = (count_reg != '0) ? len_raw : 2'd0;
    assign inst_pc_o    = head_pc_reg;
    assign inst_valid_o = (count_reg >= CW'(need)) && !redirect_i;

    assign push     = req_reg && mem_ack_i && (state_reg == RUN) && !redirect_i;
    assign pop      = inst_valid_o && inst_ready_i;
    assign pop_n    = pop ? CW'(need) : '0;
    assign redir_pc = redirect_pc_i & ~25'h1;

    assign mem_req_o  = req_reg;
    assign mem_addr_o = addr_reg;

    // Next-state: queue bookkeeping, fetch PC and request generation
    always_comb begin
        state_next    = state_reg;
        fpc_next      = fpc_reg;
        head_pc_next  = head_pc_reg;
        head_ptr_next = head_ptr_reg;
        tail_ptr_next = tail_ptr_reg;
        count_next    = count_reg;
        req_next      = req_reg;
        addr_next     = addr_reg;
        case (state_reg)
            RUN: begin
                if (redirect_i) begin
                    count_next    = '0;
                    head_ptr_next = '0;
                    tail_ptr_next = '0;
                    fpc_next      = redir_pc;
                    head_pc_next  = redir_pc;
                    if (req_reg && !mem_ack_i) begin
                        // old request must stay stable until it is acked
                        state_next = DROP;
                    end else begin
                        req_next  = 1'b1;
                        addr_next = redir_pc;
                    end
                end else begin
                    count_next = count_reg + CW'(push) - pop_n;
                    if (push) begin
                        fpc_next      = fpc_reg + 25'd2;
                        tail_ptr_next = ptr_add(tail_ptr_reg, 2'd1);
                    end
                    if (pop) begin
                        head_ptr_next = ptr_add(head_ptr_reg, need);
                        head_pc_next  = head_pc_reg + 25'({need, 1'b0});
                    end
                    req_next  = (count_next < CW'(QDEPTH));
                    addr_next = fpc_next;
                end
            end
            DROP: begin
                if (redirect_i) begin
                    fpc_next     = redir_pc;
                    head_pc_next = redir_pc;
                end
                if (mem_ack_i) begin
                    state_next = RUN;
                    req_next   = 1'b1;
                    addr_next  = fpc_next;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            fpc_reg      <= RESET_PC;
            head_pc_reg  <= RESET_PC;
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
            req_reg      <= 1'b0;
            addr_reg     <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fpc_reg      <= fpc_next;
            head_pc_reg  <= head_pc_next;
            head_ptr_reg <= head_ptr_next;
            tail_ptr_reg <= tail_ptr_next;
            count_reg    <= count_next;
            req_reg      <= req_next;
            addr_reg     <= addr_next;
        end
    end

    // Queue storage; contents are meaningless once count is cleared
    always_ff @(posedge clk) begin
        if (push)
            queue_mem[tail_ptr_reg] <= mem_rdata_i;
    end

endmodule

// File: tb/tb_if_sequencer.sv
// Directed bench for if_sequencer: a behavioural halfword memory with a
// configurable wait-state count answers requests; each step checks outputs.
module tb_if_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [24:0] redirect_pc_i;
    logic        mem_req_o;
    logic [24:0] mem_addr_o;
    logic        mem_ack_i;
    logic [15:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [63:0] inst_o;
    logic [1:0]  inst_len_o;
    logic [24:0] inst_pc_o;
    logic        inst_ready_i;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_model [logic [24:0]];
    int          wait_states = 0;
    int          wait_cnt    = 0;
    int          ack_count   = 0;
    int          n_pops      = 0;
    logic [24:0] pop_pc   [32];
    logic [15:0] pop_data [32];

    if_sequencer #(.QDEPTH(4), .RESET_PC(25'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_len_o   (inst_len_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lookup(input logic [24:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply decode/redirect inputs and the memory response
    // in mid-cycle, then log any pop that takes effect at the next edge.
    task automatic cyc(input logic rdy, input logic redir, input logic [24:0] rpc);
        @(negedge clk);
        inst_ready_i  = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if (mem_req_o) begin
            if (wait_cnt == wait_states) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = lookup(mem_addr_o);
                wait_cnt    = 0;
                ack_count++;
            end else begin
                mem_ack_i   = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
        end
        #1;
        if (inst_valid_o && inst_ready_i && n_pops < 32) begin
            pop_pc[n_pops]   = inst_pc_o;
            pop_data[n_pops] = inst_o[15:0];
            n_pops++;
        end
        $display("t=%0t req=%b addr=%h ack=%b valid=%b pc=%h len=%0d inst=%h",
                 $time, mem_req_o, mem_addr_o, mem_ack_i, inst_valid_o,
                 inst_pc_o, inst_len_o, inst_o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 25'h0);
        cyc(1'b0, 1'b0, 25'h0);
        mem_model.delete();
        wait_cnt  = 0;
        ack_count = 0;
        n_pops    = 0;
    endtask

    initial begin
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 25'h0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = 16'h0;
        inst_ready_i  = 1'b0;

        // Reset state
        cyc(1'b0, 1'b0, 25'h0);
        cyc(1'b0, 1'b0, 25'h0);
        chk("rst_req",   64'(mem_req_o),    64'h0);
        chk("rst_addr",  64'(mem_addr_o),   64'h0);
        chk("rst_valid", 64'(inst_valid_o), 64'h0);
        chk("rst_inst",  inst_o,            64'h0);
        chk("rst_len",   64'(inst_len_o),   64'h0);
        chk("rst_pc",    64'(inst_pc_o),    64'h0);

        // Zero-wait memory, three 16-bit instructions
        do_reset();
        mem_model[25'h0] = 16'h11C1;
        mem_model[25'h2] = 16'h125F;
        mem_model[25'h4] = 16'h1141;
        wait_states = 0;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 25'h0);
        chk("t1_req0",   64'(mem_req_o),    64'h1);
        chk("t1_addr0",  64'(mem_addr_o),   64'h0);
        chk("t1_valid0", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t1_valid1", 64'(inst_valid_o), 64'h1);
        chk("t1_pc1",    64'(inst_pc_o),    64'h0);
        chk("t1_inst1",  inst_o,            64'h11C1);
        chk("t1_len1",   64'(inst_len_o),   64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t1_valid2", 64'(inst_valid_o), 64'h1);
        chk("t1_pc2",    64'(inst_pc_o),    64'h2);
        chk("t1_inst2",  inst_o,            64'h125F);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t1_valid3", 64'(inst_valid_o), 64'h1);
        chk("t1_pc3",    64'(inst_pc_o),    64'h4);
        chk("t1_inst3",  inst_o,            64'h1141);

        // 32-bit instruction
        do_reset();
        mem_model[25'h0] = 16'h1EC1;
        mem_model[25'h2] = 16'h000B;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 25'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t2_valid_half", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t2_valid", 64'(inst_valid_o), 64'h1);
        chk("t2_len",   64'(inst_len_o),   64'h1);
        chk("t2_inst",  inst_o,            64'h0000_0000_000B_1EC1);
        chk("t2_pc",    64'(inst_pc_o),    64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t2_next_pc", 64'(inst_pc_o),  64'h4);

        // 48-bit instruction
        do_reset();
        mem_model[25'h0] = 16'h0621;
        mem_model[25'h2] = 16'h5678;
        mem_model[25'h4] = 16'h1234;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 25'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t3_valid_1hw", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t3_valid_2hw", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t3_valid", 64'(inst_valid_o), 64'h1);
        chk("t3_len",   64'(inst_len_o),   64'h2);
        chk("t3_inst",  inst_o,            64'h0000_1234_5678_0621);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t3_next_pc", 64'(inst_pc_o),  64'h6);

        // Backpressure with a full queue
        do_reset();
        for (int k = 0; k < 16; k++)
            mem_model[25'(2*k)] = 16'h0050 + 16'(k);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++)
            cyc(1'b0, 1'b0, 25'h0);
        chk("t4_acks",   64'(ack_count),    64'd4);
        chk("t4_req_off", 64'(mem_req_o),   64'h0);
        chk("t4_valid",  64'(inst_valid_o), 64'h1);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t4_acks_hold", 64'(ack_count), 64'd4);
        cyc(1'b0, 1'b0, 25'h0);
        chk("t4_req_on", 64'(mem_req_o),    64'h1);
        chk("t4_addr",   64'(mem_addr_o),   64'h8);
        chk("t4_pc_after", 64'(inst_pc_o),  64'h2);
        for (int k = 0; k < 7; k++)
            cyc(1'b1, 1'b0, 25'h0);
        chk("t4_npops", 64'(n_pops), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t4_pop_pc",   64'(pop_pc[k]),   64'(2*k));
            chk("t4_pop_data", 64'(pop_data[k]), 64'h50 + 64'(k));
        end

        // Redirect while a wait-stated request is outstanding
        do_reset();
        mem_model[25'h0]   = 16'h1111;
        mem_model[25'h100] = 16'h0003;
        mem_model[25'h102] = 16'h0004;
        wait_states = 3;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 25'h0);
        chk("t5_req",  64'(mem_req_o),  64'h1);
        cyc(1'b1, 1'b1, 25'h100);
        chk("t5_valid_redir", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t5_hold_req",  64'(mem_req_o),  64'h1);
        chk("t5_hold_addr", 64'(mem_addr_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t5_ack_addr", 64'(mem_addr_o),  64'h0);
        chk("t5_ack_valid", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t5_new_req",  64'(mem_req_o),  64'h1);
        chk("t5_new_addr", 64'(mem_addr_o), 64'h100);
        chk("t5_new_valid", 64'(inst_valid_o), 64'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 25'h0);
            chk("t5_wait_valid", 64'(inst_valid_o), 64'h0);
        end
        cyc(1'b1, 1'b0, 25'h0);
        chk("t5_valid", 64'(inst_valid_o), 64'h1);
        chk("t5_pc",    64'(inst_pc_o),    64'h100);
        chk("t5_inst",  inst_o,            64'h0003);

        // Redirect coinciding with ack and pop, to the top of the address space
        do_reset();
        mem_model[25'h0]       = 16'h0001;
        mem_model[25'h2]       = 16'h0002;
        mem_model[25'h1FFFFFE] = 16'h0007;
        wait_states = 0;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 25'h0);
        cyc(1'b1, 1'b1, 25'h1FFFFFF);
        chk("t6_redir_valid", 64'(inst_valid_o), 64'h0);
        chk("t6_redir_addr",  64'(mem_addr_o),   64'h2);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t6_req",   64'(mem_req_o),    64'h1);
        chk("t6_addr",  64'(mem_addr_o),   64'h1FFFFFE);
        chk("t6_flush", 64'(inst_valid_o), 64'h0);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t6_wrap_addr", 64'(mem_addr_o),   64'h0);
        chk("t6_valid",     64'(inst_valid_o), 64'h1);
        chk("t6_pc",        64'(inst_pc_o),    64'h1FFFFFE);
        chk("t6_inst",      inst_o,            64'h0007);
        cyc(1'b1, 1'b0, 25'h0);
        chk("t6_pc_wrap",   64'(inst_pc_o),    64'h0);
        chk("t6_inst_wrap", inst_o,            64'h0001);
        chk("t6_req_live",  64'(mem_req_o),    64'h1);

        // Asynchronous reset mid-transaction
        rst_n = 1'b0;
        #1;
        chk("async_req",   64'(mem_req_o),    64'h0);
        chk("async_valid", 64'(inst_valid_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_sequencer.md
# if_sequencer

Fetch sequencer sitting between instruction memory and the decode stage. It owns the fetch PC, issues halfword reads to memory over a request/acknowledge handshake, and buffers the returned halfwords in a small queue. It assembles complete variable-length instructions (16/32/48-bit) and presents them to decode with valid/ready. It also flushes and restarts fetch on a branch redirect.

## Interface
- QDEPTH, 4: queue depth in halfwords; legal range 3..8.
- RESET_PC, 25'h0: byte address of the first fetch after reset; bit 0 must be 0.

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  25  redirect byte address; bit 0 ignored (treated as 0).
- mem_req_o  out  1  halfword read request.
- mem_addr_o  out  25  byte address of the request; bit 0 always 0.
- mem_ack_i  in  1  request accepted; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  16  returned halfword.
- inst_valid_o  out  1  complete instruction available.
- inst_o  out  64  instruction: halfword0 in [15:0], halfword1 in [31:16], halfword2 in [47:32]; unused bits 0.
- inst_len_o  out  2  0 = 16-bit, 1 = 32-bit, 2 = 48-bit.
- inst_pc_o  out  25  byte address of halfword0.
- inst_ready_i  in  1  decode accepts the instruction.

## Operation
- State: fetch PC `fpc`, and a circular halfword queue with head pointer, tail pointer and `count`. `head_pc` is the address of the queue head. The FSM has states RUN and DROP.
- **Memory handshake**
  - At most one request is outstanding; the outstanding request is mem_req_o itself.
  - Once mem_req_o is asserted, mem_req_o and mem_addr_o hold stable until mem_ack_i.
  - The transfer completes in the cycle where mem_req_o && mem_ack_i.
- **Request issue (RUN)**
  - mem_req_o is registered.
  - Next cycle's mem_req_o = 1 iff `count_next < QDEPTH`, where `count_next` includes this cycle's push and pop.
  - On ack: push mem_rdata_i at the tail, `fpc += 2`, and mem_addr_o = new `fpc`.
- **Length decode** of the head halfword h:
  - h[10:5] == 6'b110001 && h[15:11] == 0 → 48-bit.
  - Else h[10:9] == 2'b11 → 32-bit.
  - Else → 16-bit.
  - inst_len_o is 0/1/2 accordingly; halfwords needed = len+1.
- **Output**
  - inst_valid_o = (count ≥ halfwords needed) && !redirect_i. It is combinational from registered queue state and redirect_i only.
  - inst_o, inst_len_o and inst_pc_o are driven from the queue whenever count ≥ 1; they are don't-care otherwise.
- **Pop** on inst_valid_o && inst_ready_i:
  - Remove len+1 halfwords.
  - `head_pc += 2*(len+1)`, modulo 2^25.
  - Push and pop in the same cycle are both applied.
- **Redirect** has priority over push and pop:
  - Set count = 0, `fpc` = `head_pc` = {redirect_pc_i[24:1], 0}.
  - If mem_req_o is high and mem_ack_i is low in the redirect cycle: enter DROP, keeping the old request stable until it is acked. The acked data is discarded and the queue is not written. Next cycle: mem_req_o = 1 with mem_addr_o = `fpc`, back in RUN.
  - If mem_ack_i coincides with redirect_i: the data is discarded, and the next cycle issues a request to the redirect address.
  - A redirect while in DROP updates `fpc` only; the FSM stays in DROP.
- **Address wrap:** 25-bit `fpc` wraps 0x1FFFFFE → 0x0000000.

## Timing
- **Reset values**
  - mem_req_o = 0, mem_addr_o = RESET_PC, inst_valid_o = 0.
  - inst_o = 0, inst_len_o = 0, inst_pc_o = RESET_PC.
  - count = 0, FSM in RUN.
- **After reset release:** mem_req_o = 1 with mem_addr_o = RESET_PC on the first rising edge after rst_n goes high.
- **Reset mid-transaction:** mem_req_o drops immediately and asynchronously; queue contents are lost.
- **Throughput:** with zero-wait memory (ack tied high), one halfword per cycle with back-to-back requests.
- **Latency:** a 16-bit instruction is valid the cycle after its ack; a 32-bit instruction is valid the cycle after its second ack.
- **Full queue:** mem_req_o deasserts the cycle after the ack that fills the queue. It reasserts the cycle after a pop frees space.
- **Redirect restart:** from redirect_i to the first new request: 1 cycle in RUN; ack-of-old + 1 cycle in DROP.

## Test plan
- **Reset then zero-wait memory**, halfwords 0x11C1, 0x125F, 0x1141 at 0x0/0x2/0x4, ready = 1 → three 16-bit instructions with inst_pc_o 0x0, 0x2, 0x4 on consecutive cycles; first valid 2 cycles after reset release.
- **32-bit ANDI**: 0x1EC1 then 0x000B → inst_len_o = 1, inst_o[31:0] = 0x000B_1EC1, single valid cycle.
- **48-bit MOV imm32**: 0x0621, 0x5678, 0x1234 → inst_len_o = 2, inst_o[47:0] = 0x1234_5678_0621; valid only after the third halfword arrives.
- **Backpressure**: ready = 0 with QDEPTH = 4 → exactly 4 acks, then mem_req_o = 0. Raising ready pops one and restarts the request the next cycle; no halfword lost or duplicated.
- **Redirect during a wait-stated request** (ack delayed 3 cycles) to 0x100 → old address held until ack, data discarded, next request to 0x100. inst_valid_o stays low until 0x100 data arrives; inst_pc_o = 0x100.
- **Redirect coincident with ack and with pop**, plus a redirect to 0x1FFFFFE → queue flushed, no pop counted; fetch addresses 0x1FFFFFE then 0x0000000.
